// File: rtl/sa_out_collector.sv
// Output collector for the systolic array. It captures skewed per-column results,
// assembles them into complete rows in a DEPTH-slot ring, and hands rows out over valid/ready.
module sa_out_collector #(
    parameter int N     = 64,
    parameter int DEPTH = 4
) (
    input  logic                I_CLK,
    input  logic                I_RST_N,
    input  logic                I_START_FLAG,
    input  logic [15:0]         I_ROWS,
    input  logic [N-1:0]        I_OUT_VLD,
    input  logic [N*16-1:0]     I_OUT,
    output logic                O_ROW_VLD,
    input  logic                I_ROW_RDY,
    output logic [N*16-1:0]     O_ROW,
    output logic [15:0]         O_ROW_IDX,
    output logic                O_DONE,
    output logic                O_OVF,
    output logic                O_BUSY
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [15:0]       rows_tgt;
    logic [15:0]       row_cnt;
    logic [AW-1:0]     rptr;
    logic [AW-1:0]     wptr [N];
    logic [N-1:0]      fill [DEPTH];
    logic [N*16-1:0]   slot [DEPTH];
    logic              ovf;
    logic [N-1:0]      wr_en;
    logic              start;
    logic              row_vld;
    logic              xfer;

    assign start   = (state == IDLE) && I_START_FLAG;
    assign row_vld = (state == COLLECT) && (&fill[rptr]);
    assign xfer    = row_vld && I_ROW_RDY;

    // A column may write only if its own target slot is free before this edge.
    // A same-edge drain of that slot does not free it in time.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no latch is inferred.
        wr_en = '0;
        for (int c = 0; c < N; c++) begin
            wr_en[c] = (state == COLLECT) && I_OUT_VLD[c] && !fill[wptr[c]][c];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (I_START_FLAG) begin
                    state_nxt = (I_ROWS == 16'd0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (xfer && ((row_cnt + 16'd1) == rows_tgt)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state    <= IDLE;
            rows_tgt <= '0;
            row_cnt  <= '0;
            rptr     <= '0;
            ovf      <= 1'b0;
            for (int c = 0; c < N; c++) wptr[c] <= '0;
            for (int d = 0; d < DEPTH; d++) fill[d] <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                rows_tgt <= I_ROWS;
                row_cnt  <= '0;
                rptr     <= '0;
                ovf      <= 1'b0;
                for (int c = 0; c < N; c++) wptr[c] <= '0;
                for (int d = 0; d < DEPTH; d++) fill[d] <= '0;
            end else begin
                // The drained slot is full, so no write can target it in the same cycle.
                if (xfer) begin
                    fill[rptr] <= '0;
                    rptr       <= rptr + AW'(1);
                    row_cnt    <= row_cnt + 16'd1;
                end
                for (int c = 0; c < N; c++) begin
                    if (wr_en[c]) begin
                        fill[wptr[c]][c] <= 1'b1;
                        wptr[c]          <= wptr[c] + AW'(1);
                    end
                end
                if ((state == COLLECT) && (|(I_OUT_VLD & ~wr_en))) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    // NOTE: slot data is not reset. Fill bits alone say what is valid, and O_ROW is gated by them.
    always_ff @(posedge I_CLK) begin
        for (int c = 0; c < N; c++) begin
            if (wr_en[c]) begin
                slot[wptr[c]][c*16 +: 16] <= I_OUT[c*16 +: 16];
            end
        end
    end

    assign O_ROW_VLD = row_vld;
    assign O_ROW     = row_vld ? slot[rptr] : '0;
    assign O_ROW_IDX = row_cnt;
    assign O_DONE    = (state == DONE);
    assign O_BUSY    = (state != IDLE);
    assign O_OVF     = ovf;

endmodule

// File: tb/tb_sa_out_collector.sv
// Self-checking bench for sa_out_collector. It runs table vectors, directed corner sequences,
// and random traffic checked against a per-column queue model.
module tb_sa_out_collector;

    localparam int N     = 4;
    localparam int DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_flag = 1'b0;
    logic [15:0]       rows = '0;
    logic [N-1:0]      out_vld = '0;
    logic [N*16-1:0]   out_bus = '0;
    logic              row_rdy = 1'b0;
    logic              row_vld;
    logic [N*16-1:0]   row;
    logic [15:0]       row_idx;
    logic              done;
    logic              ovf;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sa_out_collector #(.N(N), .DEPTH(DEPTH)) dut (
        .I_CLK        (clk),
        .I_RST_N      (rst_n),
        .I_START_FLAG (start_flag),
        .I_ROWS       (rows),
        .I_OUT_VLD    (out_vld),
        .I_OUT        (out_bus),
        .O_ROW_VLD    (row_vld),
        .I_ROW_RDY    (row_rdy),
        .O_ROW        (row),
        .O_ROW_IDX    (row_idx),
        .O_DONE       (done),
        .O_OVF        (ovf),
        .O_BUSY       (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each column holds a FIFO of undelivered elements of capacity DEPTH.
    // A row is ready when every column FIFO is non-empty.
    int              m_state;  // 0 idle, 1 collecting, 2 done
    logic [15:0]     m_tgt;
    logic [15:0]     m_cnt;
    logic            m_ovf;
    logic [15:0]     m_q [N][DEPTH];
    int              m_n [N];

    function automatic logic m_row_vld();
        logic all_full;
        all_full = 1'b1;
        for (int c = 0; c < N; c++) if (m_n[c] == 0) all_full = 1'b0;
        return (m_state == 1) && all_full;
    endfunction

    function automatic logic [N*16-1:0] m_row();
        logic [N*16-1:0] r;
        for (int c = 0; c < N; c++) r[c*16 +: 16] = m_q[c][0];
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_tgt   = '0;
        m_cnt   = '0;
        m_ovf   = 1'b0;
        for (int c = 0; c < N; c++) m_n[c] = 0;
    endtask

    task automatic model_step();
        logic xfer;
        logic acc [N];
        xfer = m_row_vld() && row_rdy;
        case (m_state)
            0: begin
                if (start_flag) begin
                    m_tgt = rows;
                    m_cnt = '0;
                    m_ovf = 1'b0;
                    for (int c = 0; c < N; c++) m_n[c] = 0;
                    m_state = (rows == 16'd0) ? 2 : 1;
                end
            end
            1: begin
                for (int c = 0; c < N; c++) begin
                    acc[c] = out_vld[c] && (m_n[c] < DEPTH);
                    if (out_vld[c] && !acc[c]) m_ovf = 1'b1;
                end
                if (xfer) begin
                    for (int c = 0; c < N; c++) begin
                        for (int k = 0; k < DEPTH - 1; k++) m_q[c][k] = m_q[c][k+1];
                        m_n[c]--;
                    end
                    m_cnt = m_cnt + 16'd1;
                    if (m_cnt == m_tgt) m_state = 2;
                end
                for (int c = 0; c < N; c++) begin
                    if (acc[c]) begin
                        m_q[c][m_n[c]] = out_bus[c*16 +: 16];
                        m_n[c]++;
                    end
                end
            end
            default: m_state = 0;
        endcase
    endtask

    // Compare every output with the model, then advance one clock.
    task automatic cycle();
        check("row_vld", 64'(row_vld), 64'(m_row_vld()));
        if (m_row_vld()) check("row", row, m_row());
        check("row_idx", 64'(row_idx), 64'(m_cnt));
        check("done", 64'(done), 64'(m_state == 2));
        check("busy", 64'(busy), 64'(m_state != 0));
        check("ovf", 64'(ovf), 64'(m_ovf));
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic st, input logic [15:0] r, input logic [N-1:0] v,
                         input logic [N*16-1:0] d, input logic rdy);
        start_flag = st;
        rows       = r;
        out_vld    = v;
        out_bus    = d;
        row_rdy    = rdy;
    endtask

    task automatic do_reset();
        drive(1'b0, 16'd0, '0, '0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct packed {
        logic            start;
        logic [15:0]     rows;
        logic [N-1:0]    vld;
        logic [N*16-1:0] data;
        logic            rdy;
        logic            e_vld;
        logic [N*16-1:0] e_row;
        logic [15:0]     e_idx;
        logic            e_done;
        logic            e_busy;
        logic            e_ovf;
    } vec_t;

    vec_t tbl [7];

    initial begin
        // Skewed single-row job: inputs applied, then outputs expected after the edge.
        tbl[0] = '{1'b1, 16'd1, 4'b0000, 64'h0,                   1'b1, 1'b0, 64'h0,                   16'd0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 16'd0, 4'b0001, 64'h0000_0000_0000_2000, 1'b1, 1'b0, 64'h0,                   16'd0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 16'd0, 4'b0010, 64'h0000_0000_E000_0000, 1'b1, 1'b0, 64'h0,                   16'd0, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 16'd0, 4'b0100, 64'h0000_0001_0000_0000, 1'b1, 1'b0, 64'h0,                   16'd0, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 16'd0, 4'b1000, 64'h7FFF_0000_0000_0000, 1'b1, 1'b1, 64'h7FFF_0001_E000_2000, 16'd0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 16'd0, 4'b0000, 64'h0,                   1'b1, 1'b0, 64'h0,                   16'd1, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 16'd0, 4'b0000, 64'h0,                   1'b1, 1'b0, 64'h0,                   16'd1, 1'b0, 1'b0, 1'b0};

        model_reset();
        #3;
        check("rst_row_vld", 64'(row_vld), 64'd0);
        check("rst_row", row, 64'd0);
        check("rst_row_idx", 64'(row_idx), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        do_reset();

        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].start, tbl[i].rows, tbl[i].vld, tbl[i].data, tbl[i].rdy);
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_vld", i), 64'(row_vld), 64'(tbl[i].e_vld));
            if (tbl[i].e_vld) check($sformatf("tbl%0d_row", i), row, tbl[i].e_row);
            check($sformatf("tbl%0d_idx", i), 64'(row_idx), 64'(tbl[i].e_idx));
            check($sformatf("tbl%0d_done", i), 64'(done), 64'(tbl[i].e_done));
            check($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
            check($sformatf("tbl%0d_ovf", i), 64'(ovf), 64'(tbl[i].e_ovf));
        end

        // Column 0 runs ahead by three elements; the third is dropped.
        do_reset();
        drive(1'b1, 16'd3, '0, '0, 1'b0); cycle();
        drive(1'b0, 16'd0, 4'b0001, 64'h0000_0000_0000_1111, 1'b0); cycle();
        drive(1'b0, 16'd0, 4'b0001, 64'h0000_0000_0000_2222, 1'b0); cycle();
        drive(1'b0, 16'd0, 4'b0001, 64'h0000_0000_0000_3333, 1'b0); cycle();
        check("ovf_col0_overrun", 64'(ovf), 64'd1);
        drive(1'b0, 16'd0, 4'b1110, 64'hA3A3_A2A2_A1A1_0000, 1'b0); cycle();
        drive(1'b0, 16'd0, 4'b1110, 64'hB3B3_B2B2_B1B1_0000, 1'b0); cycle();
        drive(1'b0, 16'd0, 4'b0000, 64'h0, 1'b0); cycle();
        check("ovf_row0", row, 64'hA3A3_A2A2_A1A1_1111);
        drive(1'b0, 16'd0, 4'b0000, 64'h0, 1'b1); cycle();
        check("ovf_row1_idx", 64'(row_idx), 64'd1);
        check("ovf_row1", row, 64'hB3B3_B2B2_B1B1_2222);
        cycle();
        drive(1'b0, 16'd0, 4'b1111, 64'hC3C3_C2C2_C1C1_C0C0, 1'b1); cycle();
        drive(1'b0, 16'd0, 4'b0000, 64'h0, 1'b1); cycle();
        check("ovf_job_done", 64'(done), 64'd1);
        cycle();

        // Two full rows buffered, then held under backpressure.
        drive(1'b1, 16'd2, '0, '0, 1'b0); cycle();
        drive(1'b0, 16'd0, 4'b1111, 64'h0303_0202_0101_0000, 1'b0); cycle();
        drive(1'b0, 16'd0, 4'b1111, 64'h1313_1212_1111_1010, 1'b0); cycle();
        drive(1'b0, 16'd0, 4'b0000, 64'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("bp_row_stable", row, 64'h0303_0202_0101_0000);
            cycle();
        end
        drive(1'b0, 16'd0, 4'b0000, 64'h0, 1'b1);
        check("bp_idx0", 64'(row_idx), 64'd0);
        cycle();
        check("bp_idx1_vld", 64'(row_vld), 64'd1);
        check("bp_idx1", 64'(row_idx), 64'd1);
        cycle();
        cycle();

        // Column 2 writes into the slot being drained in the same cycle.
        drive(1'b1, 16'd2, '0, '0, 1'b0); cycle();
        drive(1'b0, 16'd0, 4'b1111, 64'h4444_5555_6666_7777, 1'b0); cycle();
        drive(1'b0, 16'd0, 4'b0100, 64'h0000_8888_0000_0000, 1'b0); cycle();
        drive(1'b0, 16'd0, 4'b0100, 64'h0000_9999_0000_0000, 1'b1);
        check("same_edge_row", row, 64'h4444_5555_6666_7777);
        cycle();
        check("same_edge_ovf", 64'(ovf), 64'd1);
        drive(1'b0, 16'd0, 4'b1011, 64'hAAAA_0000_BBBB_CCCC, 1'b0); cycle();
        drive(1'b0, 16'd0, 4'b0000, 64'h0, 1'b1);
        check("same_edge_row1", row, 64'hAAAA_8888_BBBB_CCCC);
        cycle(); cycle(); cycle();

        // Zero-row job.
        drive(1'b1, 16'd0, '0, '0, 1'b1); cycle();
        drive(1'b0, 16'd0, 4'b1111, 64'h1234_1234_1234_1234, 1'b1);
        check("zero_rows_done", 64'(done), 64'd1);
        cycle();
        check("zero_rows_busy", 64'(busy), 64'd0);
        cycle();

        // Reset while a full row is pending and overflow is set.
        drive(1'b1, 16'd2, '0, '0, 1'b0); cycle();
        drive(1'b0, 16'd0, 4'b1111, 64'h5151_5252_5353_5454, 1'b0); cycle();
        drive(1'b0, 16'd0, 4'b0001, 64'h0000_0000_0000_6666, 1'b0); cycle();
        cycle();
        drive(1'b0, 16'd0, 4'b0000, 64'h0, 1'b0);
        rst_n = 1'b0;
        #2;
        check("midrst_row_vld", 64'(row_vld), 64'd0);
        check("midrst_row", row, 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_ovf", 64'(ovf), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        do_reset();
        drive(1'b1, 16'd1, '0, '0, 1'b1); cycle();
        drive(1'b0, 16'd0, 4'b1111, 64'h7777_6666_5555_4444, 1'b1); cycle();
        drive(1'b0, 16'd0, 4'b0000, 64'h0, 1'b1);
        check("post_rst_row", row, 64'h7777_6666_5555_4444);
        cycle();
        check("post_rst_done", 64'(done), 64'd1);
        check("post_rst_ovf", 64'(ovf), 64'd0);
        cycle();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 19) == 0), 16'($urandom_range(0, 5)), N'($urandom),
                  {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
            cycle();
        end
        drive(1'b0, 16'd0, '0, '0, 1'b1);
        repeat (4) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sa_out_collector.md
# sa_out_collector

Output-side companion of the systolic array: captures the skewed per-column results leaving the array's bottom edge, re-aligns them into complete result rows, and hands each row to the downstream writer over a valid/ready handshake. Holds up to DEPTH partially or fully assembled rows, so columns may run ahead of one another and of the consumer. Flags overflow instead of stalling the array, which has no backpressure input.

## Interface
- N, 64, number of array columns (elements per row)
- DEPTH, 4, row slots in the realignment buffer (power of two, ≥2)
- I_CLK  in  1  clock
- I_RST_N  in  1  reset, asynchronous, active-low
- I_START_FLAG  in  1  one-cycle pulse; starts a collection job (ignored unless IDLE)
- I_ROWS  in  16  rows expected in the job, sampled with I_START_FLAG
- I_OUT_VLD  in  N  per-column element valid from the array bottom edge
- I_OUT  in  N*16  per-column elements, column c at [c*16 +: 16], signed Q2.13 (1 sign, 2 int, 13 frac)
- O_ROW_VLD  out  1  assembled row available
- I_ROW_RDY  in  1  downstream accepts row
- O_ROW  out  N*16  assembled row, column c at [c*16 +: 16], bit-exact copy of captured elements
- O_ROW_IDX  out  16  index of the row on O_ROW (0-based within job)
- O_DONE  out  1  one-cycle pulse: all I_ROWS rows transferred
- O_OVF  out  1  sticky overflow: an element arrived for a column whose target slot was still occupied
- O_BUSY  out  1  high in COLLECT and DONE

## Operation
- States: IDLE, COLLECT, DONE.
- IDLE: I_OUT_VLD ignored. I_START_FLAG: latch I_ROWS into rows_tgt; clear row_cnt, rptr, all per-column wptr, all fill bits, O_OVF. If I_ROWS == 0 → DONE; else → COLLECT.
- COLLECT, per column c, on I_OUT_VLD[c]:
  - if fill[wptr_c][c] == 0 (pre-edge value): write element into slot[wptr_c] column c, set fill bit, wptr_c ← wptr_c+1 mod DEPTH.
  - else: drop element, wptr_c unchanged, O_OVF ← 1 (sticky until next start or reset).
  - All N columns are independent; any subset may be valid in a cycle.
- Row readiness: O_ROW_VLD = (state == COLLECT) && all N fill bits of slot[rptr] set. O_ROW = slot[rptr], O_ROW_IDX = row_cnt.
- Transfer (O_ROW_VLD && I_ROW_RDY): clear fill bits of slot[rptr], rptr ← rptr+1 mod DEPTH, row_cnt ← row_cnt+1. If row_cnt+1 == rows_tgt → DONE.
- Same-edge write and drain of slot[rptr] column c: write sees pre-edge fill = 1 → dropped, O_OVF set; drain still completes.
- O_ROW, O_ROW_IDX hold steady while O_ROW_VLD && !I_ROW_RDY; VLD never drops without a transfer except on reset.
- DONE: O_DONE = 1 for exactly that one cycle, → IDLE. I_OUT_VLD ignored; O_OVF retained.
- I_START_FLAG outside IDLE: ignored.

## Timing
- Reset (async assert, sync release): state IDLE, all pointers/counters/fill bits 0; O_ROW_VLD 0, O_ROW 0, O_ROW_IDX 0, O_DONE 0, O_OVF 0, O_BUSY 0. Reset mid-job discards all buffered rows.
- Element valid at edge t → fill bit set after t; if it completes slot[rptr], O_ROW_VLD high in cycle t+1 (one-cycle latency, no combinational path from I_OUT_VLD to O_ROW_VLD).
- Back-to-back rows: one transfer per cycle sustained when successive slots are full.
- Final transfer at edge t → state DONE in cycle t+1 (O_DONE high, O_BUSY high) → IDLE at t+2; new start accepted from t+2.
- I_ROWS == 0: start at edge t → O_DONE high in t+1, no row ever valid.
- rows_tgt compared exactly; row_cnt wraps at 2^16 only with I_ROWS == 0 not possible (0 handled above).

## Test plan
- N=4, DEPTH=2, I_ROWS=1: columns 0..3 valid on consecutive cycles (skew) with 0x2000,0xE000,0x0001,0x7FFF, I_ROW_RDY=1 → O_ROW_VLD high one cycle after column 3, O_ROW = {0x7FFF,0x0001,0xE000,0x2000}, O_ROW_IDX=0, O_DONE next cycle.
- N=4, DEPTH=2, I_ROWS=3, I_ROW_RDY=0 held: column 0 delivers 3 elements before any other column → third dropped, O_OVF=1; rows 0,1 later assemble and drain with IDX 0,1 when RDY=1.
- Backpressure: two full rows buffered, RDY low 5 cycles → O_ROW stable, VLD high; RDY high → rows emitted on consecutive cycles, IDX 0 then 1.
- Same-edge drain and write to slot[rptr] column 2 → row drained intact, new element dropped, O_OVF=1.
- I_ROWS=0 start → O_DONE pulse next cycle, O_ROW_VLD never high, O_BUSY high one cycle.
- Assert I_RST_N=0 mid-job with one full row pending → all outputs 0 immediately; after release, fresh job with I_ROWS=1 completes normally, O_OVF=0.
